// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory slave for the MEM-stage request interface. It accepts one load
//   or store at a time, idles for WAIT_CYCLES wait states, performs a byte-lane
//   masked access on a 2**ADDR_WIDTH x 32-bit array, and then signals
//   completion with a single-cycle memReady pulse.
//
// Ports
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset (array is not cleared)
//   memCe     in   1   request valid, held by the initiator until memReady
//   R_MEM_EN  in   1   load request
//   W_MEM_EN  in   1   store request
//   memAddr   in   32  byte address; [1:0] ignored, lanes chosen by masks
//   wtData    in   32  lane-aligned store data
//   W_MASK    in   4   store byte-lane enables (bit k = byte k)
//   R_MASK    in   4   load byte-lane enables; unselected lanes read as 0
//   rdData    out  32  registered load data, held until the next good load
//   memReady  out  1   one-cycle completion pulse
//   memErr    out  1   qualifies memReady: request rejected, no access done
//   memBusy   out  1   high whenever the responder is not idle
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memCe,
    input  logic        R_MEM_EN,
    input  logic        W_MEM_EN,
    input  logic [31:0] memAddr,
    input  logic [31:0] wtData,
    input  logic [3:0]  W_MASK,
    input  logic [3:0]  R_MASK,
    output logic [31:0] rdData,
    output logic        memReady,
    output logic        memErr,
    output logic        memBusy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;

    // Latched request; only this copy is used after accept.
    logic [31:2] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic [3:0]  r_rmask;
    logic        r_rd;
    logic        r_wr;

    logic [31:0] r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_access;
    logic                  w_err;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [31:0]           w_rbits;
    logic                  w_unused;

    // Byte offset within the word never selects lanes; masks do.
    assign w_unused = ^memAddr[1:0];

    assign w_err  = (r_addr[31:ADDR_WIDTH+2] != '0) || (r_rd && r_wr);
    assign w_word = r_addr[ADDR_WIDTH+1:2];

    always_comb begin
        w_rbits = '0;
        for (int k = 0; k < 4; k++) begin
            w_rbits[8*k +: 8] = {8{r_rmask[k]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        memBusy     = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                // A chip-enable with neither op enabled is not a request.
                if (memCe && (R_MEM_EN || W_MEM_EN)) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = 4'(WAIT_CYCLES);
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr  <= memAddr[31:2];
            r_wdata <= wtData;
            r_wmask <= W_MASK;
            r_rmask <= R_MASK;
            r_rd    <= R_MEM_EN;
            r_wr    <= W_MEM_EN;
        end
    end

    // Reset forces the state to IDLE asynchronously, so w_access is low
    // and an interrupted store never reaches the array.
    always_ff @(posedge clk) begin
        if (w_access && r_wr && !w_err) begin
            for (int k = 0; k < 4; k++) begin
                if (r_wmask[k]) begin
                    r_mem[w_word][8*k +: 8] <= r_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdData   <= '0;
            memReady <= 1'b0;
            memErr   <= 1'b0;
        end else begin
            memReady <= w_access;
            memErr   <= w_access && w_err;
            if (w_access && r_rd && !w_err) begin
                rdData <= r_mem[w_word] & w_rbits;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ce [3];
    logic        R, W;
    logic [31:0] addr, wd;
    logic [3:0]  wm, rm;

    logic [31:0] rd   [3];
    logic        rdy  [3];
    logic        err  [3];
    logic        busy [3];

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    // Index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=1, index 2: WAIT_CYCLES=15
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .memCe(ce[0]), .R_MEM_EN(R), .W_MEM_EN(W),
        .memAddr(addr), .wtData(wd), .W_MASK(wm), .R_MASK(rm),
        .rdData(rd[0]), .memReady(rdy[0]), .memErr(err[0]), .memBusy(busy[0]));

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .memCe(ce[1]), .R_MEM_EN(R), .W_MEM_EN(W),
        .memAddr(addr), .wtData(wd), .W_MASK(wm), .R_MASK(rm),
        .rdData(rd[1]), .memReady(rdy[1]), .memErr(err[1]), .memBusy(busy[1]));

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .rst_n(rst_n), .memCe(ce[2]), .R_MEM_EN(R), .W_MEM_EN(W),
        .memAddr(addr), .wtData(wd), .W_MASK(wm), .R_MASK(rm),
        .rdData(rd[2]), .memReady(rdy[2]), .memErr(err[2]), .memBusy(busy[2]));

    always @(posedge clk) begin
        if (rdy[1] === 1'b1) pulses++;
    end

    // Reference model: one word store per (instance, word index), plus the
    // last good load result of each instance.
    logic [31:0] mdl [int];
    logic [31:0] mrd [3];

    function automatic logic [31:0] lanes(input logic [3:0] m);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = m[k] ? 8'hFF : 8'h00;
        return r;
    endfunction

    function automatic int wait_of(input int sel);
        return (sel == 0) ? 0 : (sel == 1) ? 1 : 15;
    endfunction

    task automatic model(input int sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] wmk, input logic [3:0] rmk,
                         output logic exp_err, output logic [31:0] exp_rd);
        int          key;
        logic [31:0] old;
        exp_err = (a >= 32'h0000_1000) || (r && w);
        key     = sel * 4096 + int'(a[11:2]);
        if (!exp_err && w) begin
            old      = mdl.exists(key) ? mdl[key] : 32'h0;
            mdl[key] = (old & ~lanes(wmk)) | (d & lanes(wmk));
        end
        if (!exp_err && r) begin
            mrd[sel] = (mdl.exists(key) ? mdl[key] : 32'h0) & lanes(rmk);
        end
        exp_rd = mrd[sel];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input int sel, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] wmk, input logic [3:0] rmk,
                       input bit scramble, input bit hold, input string tag);
        logic        eerr;
        logic [31:0] erd;
        int          lat;
        model(sel, r, w, a, d, wmk, rmk, eerr, erd);
        @(negedge clk);
        R = r; W = w; addr = a; wd = d; wm = wmk; rm = rmk; ce[sel] = 1'b1;
        @(posedge clk); #1;
        check({tag, ".busy_acc"}, 32'(busy[sel]), 32'd1);
        if (scramble) begin
            @(negedge clk);
            R = 1'($urandom); W = 1'($urandom); addr = $urandom; wd = $urandom;
            wm = 4'($urandom); rm = 4'($urandom);
        end
        lat = 0;
        while (rdy[sel] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(wait_of(sel) + 1));
        check({tag, ".err"},     32'(err[sel]), 32'(eerr));
        check({tag, ".rdData"},  rd[sel], erd);
        if (!hold) begin
            @(negedge clk);
            ce[sel] = 1'b0; R = 1'b0; W = 1'b0;
        end
        @(posedge clk); #1;
        check({tag, ".ready_drop"}, 32'(rdy[sel]),  32'd0);
        check({tag, ".busy_idle"},  32'(busy[sel]), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic        r, w;
        int          op;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin ce[i] = 1'b0; mrd[i] = 32'h0; end
        R = 1'b0; W = 1'b0; addr = '0; wd = '0; wm = '0; rm = '0;

        // Reset state of all three instances
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst.rdData", rd[i], 32'h0);
            check("rst.ready",  32'(rdy[i]),  32'd0);
            check("rst.err",    32'(err[i]),  32'd0);
            check("rst.busy",   32'(busy[i]), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;

        // Reset in the middle of a store drops it
        req(1, 1'b0, 1'b1, 32'h10, 32'h0102_0304, 4'hF, 4'h0, 1'b0, 1'b0, "pre_store");
        @(negedge clk);
        R = 1'b0; W = 1'b1; addr = 32'h10; wd = 32'hDEAD_BEEF; wm = 4'hF; ce[1] = 1'b1;
        @(posedge clk); #1;
        check("abort.busy_acc", 32'(busy[1]), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.busy",   32'(busy[1]), 32'd0);
        check("abort.ready",  32'(rdy[1]),  32'd0);
        check("abort.err",    32'(err[1]),  32'd0);
        check("abort.rdData", rd[1],        32'h0);
        for (int i = 0; i < 3; i++) mrd[i] = 32'h0;
        ce[1] = 1'b0; W = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        req(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 4'hF, 1'b0, 1'b0, "abort_load");

        // Full store then load; then byte-lane masking
        req(1, 1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 4'h0, 1'b0, 1'b0, "full_store");
        req(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 4'hF, 1'b0, 1'b0, "full_load");
        req(1, 1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 4'h0, 1'b0, 1'b0, "lane_store");
        req(1, 1'b1, 1'b0, 32'h22, 32'h0, 4'h0, 4'b1100, 1'b0, 1'b0, "lane_load_hi");
        req(1, 1'b1, 1'b0, 32'h21, 32'h0, 4'h0, 4'b0011, 1'b0, 1'b0, "lane_load_lo");
        req(1, 1'b0, 1'b1, 32'h20, 32'h5555_5555, 4'b0000, 4'h0, 1'b0, 1'b0, "nomask_store");
        req(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 4'hF, 1'b0, 1'b0, "nomask_load");

        // Rejected requests
        req(1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 4'hF, 1'b0, 1'b0, "oor_load");
        req(1, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 4'hF, 1'b0, 1'b0, "both_en");
        req(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 4'hF, 1'b0, 1'b0, "both_en_verify");

        // Request held through DONE, then replaced by a new one
        pulses = 0;
        req(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 4'hF, 1'b0, 1'b1, "hold_load");
        req(1, 1'b0, 1'b1, 32'h24, 32'h600D_F00D, 4'hF, 4'h0, 1'b0, 1'b0, "hold_next");
        check("hold.pulses", 32'(pulses), 32'd2);

        // Wait-state extremes
        req(0, 1'b0, 1'b1, 32'h40, 32'hCAFE_0000, 4'hF, 4'h0, 1'b0, 1'b0, "w0_store");
        req(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 4'b1010, 1'b0, 1'b0, "w0_load");
        req(2, 1'b0, 1'b1, 32'h44, 32'h1234_5678, 4'hF, 4'h0, 1'b1, 1'b0, "w15_store");
        req(2, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 4'hF, 1'b1, 1'b0, "w15_load");

        // Randomized traffic on a small window of words
        for (int i = 0; i < 8; i++) begin
            req(1, 1'b0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF, 4'h0, 1'b0, 1'b0, "rnd_init");
        end
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            a  = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            r  = (op >= 4);
            w  = (op < 4) || (op == 9);
            if (op == 8) a = a | (32'h1 << $urandom_range(12, 31));
            req(1, r, w, a, $urandom, 4'($urandom), 4'($urandom), 1'($urandom), 1'b0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
